// File: rtl/rr_arbiter16.sv
// rr_arbiter16: registered round-robin arbiter for 16 requesters.
// A grant lasts until the owner signals done, drops its request, or the
// hold timer reaches MAX_HOLD. On release, the grant passes straight to the
// next requester after the old owner, so the old owner has the lowest priority.
module rr_arbiter16 #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         done_i,
    output logic [N-1:0] gnt_o,
    output logic [3:0]   gnt_idx_o,
    output logic         gnt_valid_o,
    output logic         preempt_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [3:0]   ptr_q, ptr_d;
    logic [3:0]   owner_q, owner_d;
    logic [3:0]   hold_q, hold_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         preempt_q, preempt_d;

    logic [3:0]   scanBase;
    logic [31:0]  reqTwice;
    logic [15:0]  reqRot;
    logic [3:0]   winOffset;
    logic [3:0]   winIdx;
    logic         winValid;
    logic         timeout;
    logic         ownerReq;
    logic         relGrant;

    // Rotating priority encode: rotate req so scanBase sits at bit 0, then pick the lowest set bit
    always_comb begin
        scanBase  = (state_q == BUSY) ? (owner_q + 4'd1) : ptr_q;
        reqTwice  = {req_i, req_i} >> scanBase;
        reqRot    = reqTwice[15:0];
        winValid  = 1'b0;
        winOffset = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (reqRot[i]) begin
                winValid  = 1'b1;
                winOffset = 4'(i);
            end
        end
        winIdx = scanBase + winOffset;
    end

    // Release causes for the current owner; timeout is disabled when MAX_HOLD is 0
    always_comb begin
        timeout  = (MAX_HOLD != 0) && (hold_q == 4'(MAX_HOLD));
        ownerReq = req_i[owner_q];
        relGrant = done_i || !ownerReq || timeout;
    end

    // Next-state logic for IDLE/BUSY, including same-edge handoff on release
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    state_d = BUSY;
                    owner_d = winIdx;
                    hold_d  = 4'd1;
                    gnt_d   = N'(1) << winIdx;
                    idx_d   = winIdx;
                    valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (relGrant) begin
                    ptr_d     = owner_q + 4'd1;
                    preempt_d = timeout && !done_i && ownerReq;
                    if (winValid) begin
                        owner_d = winIdx;
                        hold_d  = 4'd1;
                        gnt_d   = N'(1) << winIdx;
                        idx_d   = winIdx;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = 4'd0;
                        valid_d = 1'b0;
                    end
                end else begin
                    hold_d = (hold_q == 4'hF) ? hold_q : (hold_q + 4'd1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 4'd0;
            owner_q   <= 4'd0;
            hold_q    <= 4'd0;
            gnt_q     <= '0;
            idx_q     <= 4'd0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed and randomized checks of rr_arbiter16 against
// a behavioural round-robin model.
module tb_rr_arbiter16;

    localparam int MAXH = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_i;
    logic        done_i;
    logic [15:0] gnt_o;
    logic [3:0]  gnt_idx_o;
    logic        gnt_valid_o;
    logic        preempt_o;

    int checks;
    int failures;

    int mPtr;
    int mOwner;
    int mHold;
    bit mValid;
    bit mPreempt;

    rr_arbiter16 #(.N(16), .MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .preempt_o   (preempt_o)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // First requester found walking from base upward with wrap-around, -1 if none
    function automatic int findWinner(input logic [15:0] r, input int base);
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (base + k) % 16;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mPtr = 0; mOwner = 0; mHold = 0; mValid = 0; mPreempt = 0;
    endtask

    // One clock edge of the reference arbiter
    task automatic modelStep(input logic [15:0] r, input logic d);
        int w;
        bit tmo;
        bit ownReq;
        mPreempt = 0;
        if (!mValid) begin
            w = findWinner(r, mPtr);
            if (w >= 0) begin
                mValid = 1; mOwner = w; mHold = 1;
            end
        end else begin
            tmo    = (MAXH != 0) && (mHold == MAXH);
            ownReq = r[mOwner];
            if (d || !ownReq || tmo) begin
                mPreempt = tmo && !d && ownReq;
                mPtr = (mOwner + 1) % 16;
                w = findWinner(r, mPtr);
                if (w >= 0) begin
                    mOwner = w; mHold = 1;
                end else begin
                    mValid = 0;
                end
            end else begin
                mHold = mHold + 1;
            end
        end
    endtask

    task automatic compareModel(input string tag);
        logic [15:0] expGnt;
        logic [3:0]  expIdx;
        expGnt = mValid ? (16'd1 << mOwner) : 16'd0;
        expIdx = mValid ? 4'(mOwner) : 4'd0;
        checkOutput({tag, ".gnt"}, 32'(gnt_o), 32'(expGnt));
        checkOutput({tag, ".idx"}, 32'(gnt_idx_o), 32'(expIdx));
        checkOutput({tag, ".valid"}, 32'(gnt_valid_o), 32'(mValid));
        checkOutput({tag, ".preempt"}, 32'(preempt_o), 32'(mPreempt));
        checkOutput({tag, ".onehot"}, 32'($countones(gnt_o) <= 1), 32'd1);
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare
    task automatic applyStimulus(input logic [15:0] r, input logic d, input string tag);
        req_i  = r;
        done_i = d;
        @(posedge clk);
        #1;
        modelStep(r, d);
        compareModel(tag);
    endtask

    task automatic doReset();
        rst_n  = 1'b0;
        req_i  = 16'h0000;
        done_i = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("reset.valid", 32'(gnt_valid_o), 32'd0);
        checkOutput("reset.gnt", 32'(gnt_o), 32'd0);
        rst_n = 1'b1;
    endtask

    // Assert reset between edges and confirm outputs clear without a clock
    task automatic midGrantReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.valid", 32'(gnt_valid_o), 32'd0);
        checkOutput("midReset.gnt", 32'(gnt_o), 32'd0);
        checkOutput("midReset.idx", 32'(gnt_idx_o), 32'd0);
        checkOutput("midReset.preempt", 32'(preempt_o), 32'd0);
        modelReset();
        req_i  = 16'h0000;
        done_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [15:0] r;
        logic        d;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        req_i    = 16'h0000;
        done_i   = 1'b0;
        #2;
        doReset();

        for (int i = 0; i < 5; i++) applyStimulus(16'h0000, 1'b0, "idle");

        applyStimulus(16'h0030, 1'b0, "basic0");
        checkOutput("basic.idx4", 32'(gnt_idx_o), 32'd4);
        checkOutput("basic.gnt10", 32'(gnt_o), 32'h0010);
        applyStimulus(16'h0030, 1'b1, "basic1");
        checkOutput("basic.idx5", 32'(gnt_idx_o), 32'd5);
        checkOutput("basic.valid1", 32'(gnt_valid_o), 32'd1);
        applyStimulus(16'h0000, 1'b1, "basic2");
        checkOutput("basic.valid0", 32'(gnt_valid_o), 32'd0);

        applyStimulus(16'h8011, 1'b0, "wrap0");
        checkOutput("wrap.idx15", 32'(gnt_idx_o), 32'd15);
        applyStimulus(16'h8011, 1'b1, "wrap1");
        checkOutput("wrap.idx0", 32'(gnt_idx_o), 32'd0);
        applyStimulus(16'h8011, 1'b1, "wrap2");
        checkOutput("wrap.idx4", 32'(gnt_idx_o), 32'd4);

        midGrantReset();

        for (int i = 0; i < MAXH; i++) begin
            applyStimulus(16'h0108, 1'b0, "tmoHold");
            checkOutput("tmo.idx3", 32'(gnt_idx_o), 32'd3);
        end
        applyStimulus(16'h0108, 1'b0, "tmoFire");
        checkOutput("tmo.preempt", 32'(preempt_o), 32'd1);
        checkOutput("tmo.idx8", 32'(gnt_idx_o), 32'd8);
        applyStimulus(16'h0008, 1'b0, "tmoDrop");
        checkOutput("tmo.regrant3", 32'(gnt_idx_o), 32'd3);
        for (int i = 0; i < MAXH - 1; i++) applyStimulus(16'h0008, 1'b0, "tmoSolo");
        applyStimulus(16'h0008, 1'b0, "tmoSoloFire");
        checkOutput("tmo.soloPreempt", 32'(preempt_o), 32'd1);
        checkOutput("tmo.soloValid", 32'(gnt_valid_o), 32'd1);
        checkOutput("tmo.soloIdx", 32'(gnt_idx_o), 32'd3);

        for (int i = 0; i < MAXH - 1; i++) applyStimulus(16'h0068, 1'b0, "simHold");
        applyStimulus(16'h0048, 1'b1, "simRel");
        checkOutput("sim.preempt0", 32'(preempt_o), 32'd0);
        checkOutput("sim.idx6", 32'(gnt_idx_o), 32'd6);
        applyStimulus(16'h0008, 1'b0, "ownerDrop");
        checkOutput("ownerDrop.idx3", 32'(gnt_idx_o), 32'd3);
        checkOutput("ownerDrop.preempt0", 32'(preempt_o), 32'd0);

        midGrantReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(16'hFFFF, 1'b1, "fair");
            checkOutput("fair.seq", 32'(gnt_idx_o), 32'(i % 16));
        end

        doReset();
        r = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                r = 16'($urandom);
                if ($urandom_range(0, 1) == 1) r = r & 16'($urandom);
            end
            d = ($urandom_range(0, 4) == 0);
            applyStimulus(r, d, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
